// File: rtl/split_n_sync_if.sv
// Dual-rail link bundle for split_n_sync: input token, select, acks, outputs and error flag.
// tok_cnt exists only when SPLIT_TOKEN_CNT_EN is defined.
interface split_n_sync_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OUT = 4
);
    logic [2*WIDTH-1:0]         in;
    logic [NUM_OUT-1:0]         sel;
    logic                       ack_o;
    logic [NUM_OUT*WIDTH*2-1:0] out;
    logic [NUM_OUT-1:0]         ack_i;
    logic                       err;
`ifdef SPLIT_TOKEN_CNT_EN
    logic [NUM_OUT*16-1:0]      tok_cnt;

    modport master (output in, sel, ack_i, input ack_o, out, err, tok_cnt);
    modport slave  (input in, sel, ack_i, output ack_o, out, err, tok_cnt);
`else
    modport master (output in, sel, ack_i, input ack_o, out, err);
    modport slave  (input in, sel, ack_i, output ack_o, out, err);
`endif
endinterface

// File: rtl/split_n_sync.sv
// Clocked N-way dual-rail token splitter with input synchronisers and sticky error detection.
// Optional per-channel token counters enabled by macro SPLIT_TOKEN_CNT_EN.
module split_n_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst,
    split_n_sync_if.slave bus
);
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned OW    = NUM_OUT * DW;
    localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [1:0] WAIT_DATA = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_NULL = 2'd2;
    localparam logic [1:0] WAIT_REL  = 2'd3;

    logic [DW-1:0]      in_s;
    logic [NUM_OUT-1:0] sel_s;
    logic [NUM_OUT-1:0] ack_s;

    // Input synchronisers; the chain is cleared on reset so no partial token survives
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign in_s  = bus.in;
            assign sel_s = bus.sel;
            assign ack_s = bus.ack_i;
        end else begin : g_sync
            logic [DW-1:0]      in_p  [SYNC_STAGES];
            logic [NUM_OUT-1:0] sel_p [SYNC_STAGES];
            logic [NUM_OUT-1:0] ack_p [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        in_p[i]  <= '0;
                        sel_p[i] <= '0;
                        ack_p[i] <= '0;
                    end
                end else begin
                    in_p[0]  <= bus.in;
                    sel_p[0] <= bus.sel;
                    ack_p[0] <= bus.ack_i;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        in_p[i]  <= in_p[i-1];
                        sel_p[i] <= sel_p[i-1];
                        ack_p[i] <= ack_p[i-1];
                    end
                end
            end

            assign in_s  = in_p[SYNC_STAGES-1];
            assign sel_s = sel_p[SYNC_STAGES-1];
            assign ack_s = ack_p[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] rail_t;
    logic [WIDTH-1:0] rail_f;

    always_comb begin
        rail_t = '0;
        rail_f = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            rail_t[b] = in_s[2*b+1];
            rail_f[b] = in_s[2*b];
        end
    end

    logic in_cmpl;
    logic in_both;
    logic in_null;
    logic sel_any;
    logic sel_multi;

    assign in_cmpl   = &(rail_t ^ rail_f);
    assign in_both   = |(rail_t & rail_f);
    assign in_null   = (in_s == '0) && (sel_s == '0);
    assign sel_any   = |sel_s;
    assign sel_multi = |(sel_s & (sel_s - NUM_OUT'(1)));

    // Lowest high sel rail wins; a multi-hot select still routes but raises err
    logic [IDX_W-1:0] sel_idx;

    always_comb begin
        sel_idx = '0;
        for (int i = int'(NUM_OUT) - 1; i >= 0; i--) begin
            if (sel_s[i]) sel_idx = IDX_W'(i);
        end
    end

    logic [1:0]         state_q;
    logic [1:0]         state_nxt;
    logic [IDX_W-1:0]   k_q;
    logic [IDX_W-1:0]   k_nxt;
    logic [OW-1:0]      out_q;
    logic [OW-1:0]      out_nxt;
    logic               ack_q;
    logic               ack_nxt;
    logic               err_q;
    logic               err_c;
    logic [NUM_OUT-1:0] k_mask;
    logic               ack_k;
    logic               ack_stray;

    assign k_mask    = NUM_OUT'(1) << k_q;
    assign ack_k     = |(ack_s & k_mask);
    assign ack_stray = |(ack_s & ~k_mask);

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_DATA;
        else     state_q <= state_nxt;
    end

    // Next-state, next-output and error detection
    always_comb begin
        state_nxt = state_q;
        k_nxt     = k_q;
        out_nxt   = out_q;
        ack_nxt   = ack_q;
        err_c     = in_both | sel_multi;
        case (state_q)
            WAIT_DATA: begin
                if (|ack_s) err_c = 1'b1;
                if (in_cmpl && sel_any) begin
                    k_nxt   = sel_idx;
                    out_nxt = '0;
                    for (int i = 0; i < int'(NUM_OUT); i++) begin
                        if (IDX_W'(i) == sel_idx) out_nxt[i*DW +: DW] = in_s;
                    end
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_stray) err_c = 1'b1;
                if (ack_k) begin
                    ack_nxt   = 1'b1;
                    state_nxt = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (ack_stray) err_c = 1'b1;
                if (in_null) begin
                    out_nxt   = '0;
                    state_nxt = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (ack_stray) err_c = 1'b1;
                if (!ack_k) begin
                    ack_nxt   = 1'b0;
                    state_nxt = WAIT_DATA;
                end
            end
            default: state_nxt = WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            out_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            k_q   <= k_nxt;
            out_q <= out_nxt;
            ack_q <= ack_nxt;
            err_q <= err_q | err_c;
        end
    end

    assign bus.out   = out_q;
    assign bus.ack_o = ack_q;
    assign bus.err   = err_q;

`ifdef SPLIT_TOKEN_CNT_EN
    // Count each token at the moment its receiver acknowledges it
    logic        cnt_inc;
    logic [15:0] cnt_q [NUM_OUT];

    assign cnt_inc = (state_q == WAIT_ACK) && ack_k;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_OUT); i++) cnt_q[i] <= '0;
        end else if (cnt_inc) begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                if (IDX_W'(i) == k_q) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_OUT); g++) begin : g_cnt
        assign bus.tok_cnt[g*16 +: 16] = cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_split_n_sync.sv
// Directed self-checking bench for split_n_sync (WIDTH=8, NUM_OUT=4, SYNC_STAGES=2).
// Token counters are checked when SPLIT_TOKEN_CNT_EN is defined.
module tb_split_n_sync;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    split_n_sync_if #(.WIDTH(8), .NUM_OUT(4)) bus ();

    split_n_sync #(.WIDTH(8), .NUM_OUT(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] enc(input logic [7:0] v);
        logic [15:0] r;
        for (int b = 0; b < 8; b++) begin
            r[2*b+1] = v[b];
            r[2*b]   = ~v[b];
        end
        return r;
    endfunction

    function automatic logic [63:0] place(input int ch, input logic [15:0] d);
        return 64'(d) << (ch * 16);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        bus.in = '0; bus.sel = '0; bus.ack_i = '0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.in = '0; bus.sel = '0; bus.ack_i = '0;
        rst = 1'b1;
        tick(2);
        vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL reset_out: got %h expected %h", bus.out, 64'h0); end
        vecs++; if (bus.ack_o !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b expected 0", bus.ack_o); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            vecs++;
            if (bus.out !== 64'h0 || bus.ack_o !== 1'b0 || bus.err !== 1'b0) begin
                errs++; $display("FAIL idle_%0d: got out=%h ack=%b err=%b expected all zero", i, bus.out, bus.ack_o, bus.err);
            end
        end
    endtask

    task automatic test_single();
        bus.in = 16'h9966; bus.sel = 4'b0100;
        tick(2);
        vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL single_early: got %h expected %h", bus.out, 64'h0); end
        tick(1);
        vecs++; if (bus.out !== 64'h0000_9966_0000_0000) begin errs++; $display("FAIL single_data: got %h expected %h", bus.out, 64'h0000_9966_0000_0000); end
        bus.ack_i = 4'b0100;
        tick(2);
        vecs++; if (bus.ack_o !== 1'b0) begin errs++; $display("FAIL single_ack_early: got %b expected 0", bus.ack_o); end
        tick(1);
        vecs++; if (bus.ack_o !== 1'b1) begin errs++; $display("FAIL single_ack: got %b expected 1", bus.ack_o); end
        bus.in = '0; bus.sel = '0;
        tick(2);
        vecs++; if (bus.out !== 64'h0000_9966_0000_0000) begin errs++; $display("FAIL single_hold: got %h expected %h", bus.out, 64'h0000_9966_0000_0000); end
        tick(1);
        vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL single_null: got %h expected %h", bus.out, 64'h0); end
        bus.ack_i = '0;
        tick(3);
        vecs++; if (bus.ack_o !== 1'b0) begin errs++; $display("FAIL single_rel: got %b expected 0", bus.ack_o); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL single_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_skewed();
        logic [15:0] full;
        logic [63:0] prev;
        int          rises;
        full = 16'h9966;
        bus.in = '0; bus.sel = '0;
        for (int b = 0; b < 8; b++) begin
            bus.in[2*b +: 2] = full[2*b +: 2];
            tick(1);
            vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL skew_bit%0d: got %h expected %h", b, bus.out, 64'h0); end
        end
        bus.sel = 4'b0001;
        tick(2);
        vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL skew_sel_early: got %h expected %h", bus.out, 64'h0); end
        tick(1);
        vecs++; if (bus.out !== 64'h0000_0000_0000_9966) begin errs++; $display("FAIL skew_data: got %h expected %h", bus.out, 64'h0000_0000_0000_9966); end
        prev  = bus.out;
        rises = 1;
        bus.ack_i = 4'b0001;
        tick(3);
        bus.in = '0; bus.sel = '0;
        tick(3);
        bus.ack_i = '0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (prev == 64'h0 && bus.out != 64'h0) rises++;
            prev = bus.out;
        end
        vecs++; if (rises !== 1) begin errs++; $display("FAIL skew_once: got %0d deliveries expected 1", rises); end
        vecs++; if (bus.out !== 64'h0 || bus.ack_o !== 1'b0) begin errs++; $display("FAIL skew_end: got out=%h ack=%b expected 0/0", bus.out, bus.ack_o); end
    endtask

    task automatic test_back_to_back();
        int          chans [5] = '{0, 1, 2, 3, 0};
        logic [7:0]  data  [5] = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A};
        logic [63:0] exp;
        apply_reset();
        for (int t = 0; t < 5; t++) begin
            exp = place(chans[t], enc(data[t]));
            bus.in  = enc(data[t]);
            bus.sel = 4'(1 << chans[t]);
            tick(3);
            vecs++; if (bus.out !== exp) begin errs++; $display("FAIL b2b_data_%0d: got %h expected %h", t, bus.out, exp); end
            bus.ack_i = 4'(1 << chans[t]);
            tick(3);
            vecs++; if (bus.ack_o !== 1'b1) begin errs++; $display("FAIL b2b_ack_%0d: got %b expected 1", t, bus.ack_o); end
            bus.in = '0; bus.sel = '0;
            tick(3);
            vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL b2b_null_%0d: got %h expected %h", t, bus.out, 64'h0); end
            bus.ack_i = '0;
            tick(3);
            vecs++; if (bus.ack_o !== 1'b0) begin errs++; $display("FAIL b2b_rel_%0d: got %b expected 0", t, bus.ack_o); end
        end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL b2b_err: got %b expected 0", bus.err); end
`ifdef SPLIT_TOKEN_CNT_EN
        vecs++;
        if (bus.tok_cnt !== {16'd1, 16'd1, 16'd1, 16'd2}) begin
            errs++; $display("FAIL b2b_cnt: got %h expected %h", bus.tok_cnt, {16'd1, 16'd1, 16'd1, 16'd2});
        end
`endif
    endtask

    task automatic test_errors();
        // bit 3 with both rails high
        apply_reset();
        bus.in = 16'h99E6; bus.sel = 4'b0001;
        tick(2);
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL err_both_early: got %b expected 0", bus.err); end
        tick(1);
        vecs++; if (bus.err !== 1'b1) begin errs++; $display("FAIL err_both: got %b expected 1", bus.err); end
        bus.in = '0; bus.sel = '0;
        tick(5);
        vecs++; if (bus.err !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
        vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL err_both_out: got %h expected %h", bus.out, 64'h0); end

        // multi-hot select routes to the lowest index
        apply_reset();
        bus.in = 16'h9966; bus.sel = 4'b0110;
        tick(3);
        vecs++; if (bus.err !== 1'b1) begin errs++; $display("FAIL err_sel: got %b expected 1", bus.err); end
        vecs++; if (bus.out !== 64'h0000_0000_9966_0000) begin errs++; $display("FAIL err_sel_route: got %h expected %h", bus.out, 64'h0000_0000_9966_0000); end
        bus.ack_i = 4'b0010;
        tick(3);
        vecs++; if (bus.ack_o !== 1'b1) begin errs++; $display("FAIL err_sel_ack: got %b expected 1", bus.ack_o); end

        // stray acknowledge while channel 3 is in flight
        apply_reset();
        bus.in = enc(8'h42); bus.sel = 4'b1000;
        tick(3);
        vecs++; if (bus.out !== place(3, enc(8'h42))) begin errs++; $display("FAIL err_stray_data: got %h expected %h", bus.out, place(3, enc(8'h42))); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL err_stray_pre: got %b expected 0", bus.err); end
        bus.ack_i = 4'b0001;
        tick(3);
        vecs++; if (bus.err !== 1'b1) begin errs++; $display("FAIL err_stray: got %b expected 1", bus.err); end
        vecs++; if (bus.ack_o !== 1'b0) begin errs++; $display("FAIL err_stray_ack: got %b expected 0", bus.ack_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.in = 16'h9966; bus.sel = 4'b0100;
        tick(3);
        bus.ack_i = 4'b0100;
        tick(3);
        vecs++; if (bus.ack_o !== 1'b1) begin errs++; $display("FAIL mid_setup_ack: got %b expected 1", bus.ack_o); end
        bus.in = '0; bus.sel = '0; bus.ack_i = '0;
        rst = 1'b1;
        tick(1);
        vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL mid_out: got %h expected %h", bus.out, 64'h0); end
        vecs++; if (bus.ack_o !== 1'b0) begin errs++; $display("FAIL mid_ack: got %b expected 0", bus.ack_o); end
        rst = 1'b0;
        tick(1);
        bus.in = enc(8'h3C); bus.sel = 4'b0010;
        tick(3);
        vecs++; if (bus.out !== place(1, enc(8'h3C))) begin errs++; $display("FAIL mid_data: got %h expected %h", bus.out, place(1, enc(8'h3C))); end
        bus.ack_i = 4'b0010;
        tick(3);
        vecs++; if (bus.ack_o !== 1'b1) begin errs++; $display("FAIL mid_ack2: got %b expected 1", bus.ack_o); end
        bus.in = '0; bus.sel = '0;
        tick(3);
        vecs++; if (bus.out !== 64'h0) begin errs++; $display("FAIL mid_null: got %h expected %h", bus.out, 64'h0); end
        bus.ack_i = '0;
        tick(3);
        vecs++; if (bus.ack_o !== 1'b0) begin errs++; $display("FAIL mid_rel: got %b expected 0", bus.ack_o); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL mid_err: got %b expected 0", bus.err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skewed();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
